fft16_out_reorder: RTL and testbench
====================================

Name: fft16_out_reorder

Overview:
- Sink for the radix-4 MDC 16-point FFT datapath's serial output stream (out_r/out_i plus a sample-valid strobe).
- The datapath emits bins in radix-4 digit-reversed order; this block buffers each 16-sample frame and re-emits it in natural bin order (0..15).
- Ping-pong storage allows one frame to be written while the previous frame is read.
- Downstream sees a valid/ready stream; upstream sees a ready signal for backpressure.

Parameters:
- WL, 16, word length of each real/imag component (two's complement).
- LOG2N, 4, log2 of the frame length; fixed at 4 (N=16, two radix-4 digits). Any other value is unsupported.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_r  in  WL  real part of input sample, digit-reversed order.
- in_i  in  WL  imaginary part of input sample.
- in_valid  in  1  input sample present.
- in_ready  out  1  block can accept a sample this cycle.
- out_r  out  WL  real part, natural order.
- out_i  out  WL  imaginary part, natural order.
- out_valid  out  1  out_r/out_i hold a valid sample.
- out_ready  in  1  downstream accepts the sample this cycle.
- out_last  out  1  high with bin 15 of each frame.
- frame_drop  out  1  one-cycle pulse; a sample was offered while in_ready=0.

Behaviour:
- Reset (async assert, sync release): both banks EMPTY; wbank=0; wcnt=0; rbank=0; rcnt=0; out_r=0, out_i=0, out_valid=0, out_last=0, frame_drop=0; in_ready=1.
- Storage: two banks of 16 complex words. Each bank has a state: EMPTY, FILLING, FULL, DRAINING.
- Input accept: occurs when in_valid && in_ready.
- Write address for the k-th accepted sample (k=wcnt, 0..15), with k = 4*k1 + k0: waddr = 4*k0 + k1.
  - Example sequence: 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15.
- wcnt increments on each accept.
- On accepting k=15:
  - the write bank becomes FULL;
  - wcnt wraps to 0;
  - wbank toggles.
- in_ready = 1 iff the current write bank is EMPTY or FILLING.
- Read FSM states:
  - IDLE: waits for bank[rbank]==FULL; then marks it DRAINING and goes to READ. The first out_valid rises on the cycle after the FULL transition registers, so minimum latency from the 16th accept to bin 0 valid is 2 cycles.
  - READ: out_r/out_i are registered from bank[rbank][rcnt].
    - A transfer occurs when out_valid && out_ready.
    - Data and out_valid are held stable while out_ready=0.
    - On a transfer of rcnt<15: rcnt++ and the next word is presented the following cycle. There are no bubbles while out_ready stays high.
    - On the transfer of rcnt=15: the bank becomes EMPTY and rbank toggles. If the other bank is already FULL, bin 0 of that bank is presented on the next cycle (back-to-back frames, no bubble). Otherwise go to IDLE and drop out_valid.
- out_last = out_valid && (rcnt==15).
- Simultaneous events:
  - Write of k=15 into bank A and read-complete of bank B in the same cycle: both take effect. Bank A is FULL and bank B is EMPTY the next cycle.
  - Writing into a bank freed in the same cycle is allowed on the following cycle only.
- Overrun: when in_valid=1 and in_ready=0, the sample is discarded, frame_drop pulses, and wcnt is unchanged.
- Reset mid-frame: all partial frames are discarded; the state returns to the reset values above.
- Arithmetic: none, except under the optional feature. Data passes bit-exact.

Optional Feature:
- Macro: FFT16_OUT_REORDER_SCALE_EN.
- Defined: out_r/out_i = stored value arithmetically shifted right by LOG2N (1/N normalisation), rounded half-up. Computation: add 2^(LOG2N-1) in WL+1 bits, shift, saturate to the WL range. Applied on the read path; latency unchanged.
- Undefined: no scaling logic is compiled; data passes bit-exact.

Test Plan:
- Single frame: in_r=k, in_i=-k for k=0..15, in_valid held high, out_ready=1. Required:
  - out_r sequence 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15;
  - out_i is its negation;
  - out_last only on the 16th output;
  - bin 0 valid 2 cycles after the 16th accept.
- Back-to-back frames: 3 consecutive frames with values 0..15, 16..31, 32..47, out_ready=1. Required: 48 outputs with no gap between frames; frame 2 begins with 16,20,24,28.
- Backpressure: out_ready toggles 1,0,0,1 repeating. Required:
  - no output is lost or duplicated;
  - data is stable while stalled;
  - in_ready falls after the 2nd frame completes while frame 1 is still draining.
- Overrun: keep out_ready=0 and offer a 3rd frame. Required:
  - in_ready=0;
  - frame_drop pulses for each offered sample;
  - after out_ready=1, only frames 1 and 2 appear.
- Reset mid-frame: assert rst_n=0 after 7 samples of frame 1, then send a full frame 100..115. Required: outputs 100,104,108,112,101,...; no residue from the partial frame.
- Scale (macro defined): input 0x7FF8 real, 0x8000 imag for all k. Required: out_r=0x0800 and out_i=0xF800 for every bin.

Source files
------------

// File: rtl/fft16_out_reorder.sv
// fft16_out_reorder: ping-pong reorder buffer for the radix-4 MDC 16-point FFT.
// Frames arrive in radix-4 digit-reversed order and leave in natural bin order
// on a valid/ready stream. While one bank drains, the other can fill.
// Optional build macro FFT16_OUT_REORDER_SCALE_EN: each output word is scaled by
// 1/N (round half-up, saturated) on the read path without changing latency.
module fft16_out_reorder #(
   parameter int WL    = 16,
   parameter int LOG2N = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [WL-1:0] in_r,
   input  logic [WL-1:0] in_i,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [WL-1:0] out_r,
   output logic [WL-1:0] out_i,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_last,
   output logic          frame_drop
);

   localparam int N    = 1 << LOG2N;
   localparam int HALF = LOG2N / 2;
   localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);
   localparam logic [LOG2N-1:0] ONE      = LOG2N'(1);

   typedef enum logic [1:0] {
      B_EMPTY    = 2'd0,
      B_FILLING  = 2'd1,
      B_FULL     = 2'd2,
      B_DRAINING = 2'd3
   } bank_state_e;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_READ = 1'b1
   } rd_state_e;

`ifdef FFT16_OUT_REORDER_SCALE_EN
   localparam logic signed [WL:0] RND_HALF = (WL+1)'(1 << (LOG2N - 1));
   localparam logic signed [WL:0] SAT_MAX  = (WL+1)'((1 << (WL - 1)) - 1);
   localparam logic signed [WL:0] SAT_MIN  = (WL+1)'(-(1 << (WL - 1)));

   // 1/N normalisation: add half an LSB of the result, arithmetic shift, clamp
   function automatic logic signed [WL-1:0] rd_fmt(input logic signed [WL-1:0] x);
      logic signed [WL:0] sum;
      logic signed [WL:0] shf;
      sum = (WL+1)'(x) + RND_HALF;
      shf = sum >>> LOG2N;
      if (shf > SAT_MAX) begin
         shf = SAT_MAX;
      end else if (shf < SAT_MIN) begin
         shf = SAT_MIN;
      end
      return shf[WL-1:0];
   endfunction
`else
   // Bit-exact pass-through of the stored word
   function automatic logic signed [WL-1:0] rd_fmt(input logic signed [WL-1:0] x);
      return x;
   endfunction
`endif

   // Two banks of N complex words, indexed [bank][bin]
   logic signed [WL-1:0] mem_r_q [2][N];
   logic signed [WL-1:0] mem_i_q [2][N];

   bank_state_e          bank_q [2];
   bank_state_e          bank_d [2];
   logic                 wbank_q, wbank_d;
   logic                 rbank_q, rbank_d;
   logic [LOG2N-1:0]     wcnt_q, wcnt_d;
   logic [LOG2N-1:0]     rcnt_q, rcnt_d;
   rd_state_e            rd_state_q, rd_state_d;
   logic signed [WL-1:0] out_r_q, out_r_d;
   logic signed [WL-1:0] out_i_q, out_i_d;
   logic                 out_valid_q, out_valid_d;
   logic                 frame_drop_q, frame_drop_d;

   logic                 wr_ready;
   logic                 wr_accept;
   logic [LOG2N-1:0]     waddr;
   logic                 rd_load;
   logic                 rd_bank;
   logic [LOG2N-1:0]     rd_addr;

   // Write side: accept while the write bank is free; swap the two radix-4 digits of the count
   always_comb begin
      wr_ready  = (bank_q[wbank_q] == B_EMPTY) || (bank_q[wbank_q] == B_FILLING);
      wr_accept = in_valid && wr_ready;
      waddr     = {wcnt_q[HALF-1:0], wcnt_q[LOG2N-1:HALF]};
   end

   // Sample storage; contents need no reset because bank states gate every read
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem_r_q[wbank_q][waddr] <= $signed(in_r);
         mem_i_q[wbank_q][waddr] <= $signed(in_i);
      end
   end

   // Bank bookkeeping, write counter and read FSM next state, plus output word fetch
   always_comb begin
      bank_d       = bank_q;
      wbank_d      = wbank_q;
      wcnt_d       = wcnt_q;
      rbank_d      = rbank_q;
      rcnt_d       = rcnt_q;
      rd_state_d   = rd_state_q;
      out_valid_d  = out_valid_q;
      out_r_d      = out_r_q;
      out_i_d      = out_i_q;
      frame_drop_d = in_valid && !wr_ready;
      rd_load      = 1'b0;
      rd_bank      = rbank_q;
      rd_addr      = rcnt_q;

      // Write and read sides only ever touch banks in disjoint states, so both
      // updates can land in the same cycle without conflict.
      if (wr_accept) begin
         if (wcnt_q == LAST_IDX) begin
            bank_d[wbank_q] = B_FULL;
            wcnt_d          = '0;
            wbank_d         = ~wbank_q;
         end else begin
            bank_d[wbank_q] = B_FILLING;
            wcnt_d          = wcnt_q + ONE;
         end
      end

      case (rd_state_q)
         RD_IDLE: begin
            if (bank_q[rbank_q] == B_FULL) begin
               bank_d[rbank_q] = B_DRAINING;
               rd_state_d      = RD_READ;
               rcnt_d          = '0;
               out_valid_d     = 1'b1;
               rd_load         = 1'b1;
               rd_addr         = '0;
            end
         end
         RD_READ: begin
            if (out_valid_q && out_ready) begin
               if (rcnt_q != LAST_IDX) begin
                  rcnt_d  = rcnt_q + ONE;
                  rd_load = 1'b1;
                  rd_addr = rcnt_q + ONE;
               end else begin
                  bank_d[rbank_q] = B_EMPTY;
                  rbank_d         = ~rbank_q;
                  rcnt_d          = '0;
                  // Only a bank that was already FULL continues without a bubble
                  if (bank_q[~rbank_q] == B_FULL) begin
                     bank_d[~rbank_q] = B_DRAINING;
                     rd_load          = 1'b1;
                     rd_bank          = ~rbank_q;
                     rd_addr          = '0;
                  end else begin
                     rd_state_d  = RD_IDLE;
                     out_valid_d = 1'b0;
                  end
               end
            end
         end
         default: begin
            rd_state_d = RD_IDLE;
         end
      endcase

      if (rd_load) begin
         out_r_d = rd_fmt(mem_r_q[rd_bank][rd_addr]);
         out_i_d = rd_fmt(mem_i_q[rd_bank][rd_addr]);
      end
   end

   // State, counters and output registers with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_q[0]    <= B_EMPTY;
         bank_q[1]    <= B_EMPTY;
         wbank_q      <= 1'b0;
         rbank_q      <= 1'b0;
         wcnt_q       <= '0;
         rcnt_q       <= '0;
         rd_state_q   <= RD_IDLE;
         out_r_q      <= '0;
         out_i_q      <= '0;
         out_valid_q  <= 1'b0;
         frame_drop_q <= 1'b0;
      end else begin
         bank_q       <= bank_d;
         wbank_q      <= wbank_d;
         rbank_q      <= rbank_d;
         wcnt_q       <= wcnt_d;
         rcnt_q       <= rcnt_d;
         rd_state_q   <= rd_state_d;
         out_r_q      <= out_r_d;
         out_i_q      <= out_i_d;
         out_valid_q  <= out_valid_d;
         frame_drop_q <= frame_drop_d;
      end
   end

   assign in_ready   = wr_ready;
   assign out_r      = out_r_q;
   assign out_i      = out_i_q;
   assign out_valid  = out_valid_q;
   assign out_last   = out_valid_q && (rcnt_q == LAST_IDX);
   assign frame_drop = frame_drop_q;

endmodule

// File: tb/tb_fft16_out_reorder.sv
// tb_fft16_out_reorder: directed and randomized checks of the FFT output reorder buffer
// against a queue-based reference of frame occupancy and digit reversal.
`timescale 1ns/1ps
module tb_fft16_out_reorder;

   localparam int WL    = 16;
   localparam int LOG2N = 4;
   localparam int N     = 16;
   localparam int SEQ [16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b1;
   logic [WL-1:0] in_r      = '0;
   logic [WL-1:0] in_i      = '0;
   logic          in_valid  = 1'b0;
   logic          in_ready;
   logic [WL-1:0] out_r;
   logic [WL-1:0] out_i;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          out_last;
   logic          frame_drop;

   int n_checks  = 0;
   int n_errors  = 0;
   int cyc       = 0;
   int ordy_mode = 0;   // 0: always ready, 1: never, 2: 1,0,0,1 pattern, 3: random

   logic [WL-1:0] part_r [$];
   logic [WL-1:0] part_i [$];
   logic [WL-1:0] exp_r  [$];
   logic [WL-1:0] exp_i  [$];
   logic          exp_last [$];
   logic [WL-1:0] got_r  [$];
   logic [WL-1:0] got_i  [$];
   int            xfer_cyc [$];

   fft16_out_reorder #(.WL(WL), .LOG2N(LOG2N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_r       (in_r),
      .in_i       (in_i),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_r      (out_r),
      .out_i      (out_i),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .frame_drop (frame_drop)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Expected output word for a stored sample
   function automatic logic [WL-1:0] ref_fmt(input logic [WL-1:0] x);
`ifdef FFT16_OUT_REORDER_SCALE_EN
      int v;
      v = int'($signed(x));
      v = (v + 8) >>> 4;
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
      return WL'(v);
`else
      return x;
`endif
   endfunction

   // Storage holds at most two completed, not yet fully delivered frames
   function automatic logic model_ready();
      return ((exp_r.size() + N - 1) / N) < 2;
   endfunction

   function automatic logic get_ordy();
      case (ordy_mode)
         0:       return 1'b1;
         1:       return 1'b0;
         2:       return (cyc % 4 == 0) || (cyc % 4 == 3);
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   task automatic model_accept(input logic [WL-1:0] r, input logic [WL-1:0] i);
      part_r.push_back(r);
      part_i.push_back(i);
      if (part_r.size() == N) begin
         for (int n = 0; n < N; n++) begin
            // natural bin n holds the arrival whose two base-4 digits are swapped
            int src = (n % 4) * 4 + n / 4;
            exp_r.push_back(ref_fmt(part_r[src]));
            exp_i.push_back(ref_fmt(part_i[src]));
            exp_last.push_back(n == N - 1);
         end
         part_r.delete();
         part_i.delete();
      end
   endtask

   task automatic cycle(input logic v, input logic [WL-1:0] r, input logic [WL-1:0] i,
                        input logic ordy);
      logic mrdy, acc, drop, xf;
      in_valid  = v;
      in_r      = r;
      in_i      = i;
      out_ready = ordy;
      #1;
      mrdy = model_ready();
      chk("in_ready", 32'(in_ready), 32'(mrdy));
      if (exp_r.size() == 0) begin
         chk("spurious_valid", 32'(out_valid), 32'd0);
      end else if (out_valid) begin
         chk("out_r", 32'(out_r), 32'(exp_r[0]));
         chk("out_i", 32'(out_i), 32'(exp_i[0]));
         chk("out_last", 32'(out_last), 32'(exp_last[0]));
      end
      if (!out_valid) chk("last_without_valid", 32'(out_last), 32'd0);
      acc  = v && mrdy;
      drop = v && !mrdy;
      xf   = out_valid && ordy;
      if (xf) begin
         got_r.push_back(out_r);
         got_i.push_back(out_i);
         xfer_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
      chk("frame_drop", 32'(frame_drop), 32'(drop));
      if (xf && exp_r.size() != 0) begin
         void'(exp_r.pop_front());
         void'(exp_i.pop_front());
         void'(exp_last.pop_front());
      end
      if (acc) model_accept(r, i);
   endtask

   task automatic send_sample(input logic [WL-1:0] r, input logic [WL-1:0] i);
      int w = 0;
      while (!model_ready() && w < 300) begin
         cycle((ordy_mode == 3) ? 1'($urandom_range(0, 1)) : 1'b0, r, i, get_ordy());
         w++;
      end
      chk("send_wait_bounded", 32'(w < 300), 32'd1);
      cycle(1'b1, r, i, get_ordy());
   endtask

   task automatic send_frame(input int base);
      for (int k = 0; k < N; k++) send_sample(WL'(base + k), WL'(-(base + k)));
   endtask

   task automatic drain();
      int w = 0;
      while (exp_r.size() != 0 && w < 1000) begin
         cycle(1'b0, '0, '0, get_ordy());
         w++;
      end
      chk("drain_complete", 32'(exp_r.size()), 32'd0);
      for (int k = 0; k < 6; k++) cycle(1'b0, '0, '0, 1'b1);
   endtask

   task automatic clear_obs();
      got_r.delete();
      got_i.delete();
      xfer_cyc.delete();
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_frame_drop", 32'(frame_drop), 32'd0);
      chk("rst_out_r", 32'(out_r), 32'd0);
      chk("rst_out_i", 32'(out_i), 32'd0);
      part_r.delete();
      part_i.delete();
      exp_r.delete();
      exp_i.delete();
      exp_last.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      #2;
      do_reset();

      // Single frame, always ready: order, negated imag, last flag, 2-cycle latency
      ordy_mode = 0;
      clear_obs();
      for (int k = 0; k < N; k++) send_sample(WL'(k), WL'(-k));
      chk("lat_plus1_not_valid", 32'(out_valid), 32'd0);
      cycle(1'b0, '0, '0, 1'b1);
      chk("lat_plus2_valid", 32'(out_valid), 32'd1);
      chk("lat_plus2_bin0", 32'(out_r), 32'(ref_fmt(WL'(0))));
      drain();
      chk("single_count", 32'(got_r.size()), 32'd16);
      for (int n = 0; n < N && n < got_r.size(); n++) begin
         chk("single_seq_r", 32'(got_r[n]), 32'(ref_fmt(WL'(SEQ[n]))));
         chk("single_seq_i", 32'(got_i[n]), 32'(ref_fmt(WL'(-SEQ[n]))));
      end

      // Three frames back to back
      clear_obs();
      for (int f = 0; f < 3; f++) send_frame(16 * f);
      drain();
      chk("b2b_count", 32'(got_r.size()), 32'd48);
      if (got_r.size() == 48) begin
         chk("b2b_no_gap_f1_f2", 32'(xfer_cyc[31] - xfer_cyc[0]), 32'd31);
         chk("b2b_f2_bin0", 32'(got_r[16]), 32'(ref_fmt(WL'(16))));
         chk("b2b_f2_bin1", 32'(got_r[17]), 32'(ref_fmt(WL'(20))));
         chk("b2b_f2_bin2", 32'(got_r[18]), 32'(ref_fmt(WL'(24))));
         chk("b2b_f2_bin3", 32'(got_r[19]), 32'(ref_fmt(WL'(28))));
         chk("b2b_f3_bin0", 32'(got_r[32]), 32'(ref_fmt(WL'(32))));
      end

      // Backpressure with out_ready = 1,0,0,1 ...
      ordy_mode = 2;
      clear_obs();
      send_frame(200);
      send_frame(216);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      send_frame(232);
      drain();
      chk("bp_count", 32'(got_r.size()), 32'd48);

      // Overrun: two frames held, a third offered and discarded
      ordy_mode = 1;
      clear_obs();
      send_frame(300);
      send_frame(316);
      for (int k = 0; k < N; k++) begin
         cycle(1'b1, WL'(400 + k), WL'(-(400 + k)), 1'b0);
         chk("ovr_drop_pulse", 32'(frame_drop), 32'd1);
      end
      ordy_mode = 0;
      drain();
      chk("ovr_count", 32'(got_r.size()), 32'd32);
      if (got_r.size() == 32) chk("ovr_last_word", 32'(got_r[31]), 32'(ref_fmt(WL'(331))));

      // Reset after a partial frame, then a clean frame
      clear_obs();
      for (int k = 0; k < 7; k++) send_sample(WL'(500 + k), WL'(-(500 + k)));
      do_reset();
      send_frame(100);
      drain();
      chk("rst_mid_count", 32'(got_r.size()), 32'd16);
      for (int n = 0; n < 4 && n < got_r.size(); n++)
         chk("rst_mid_seq", 32'(got_r[n]), 32'(ref_fmt(WL'(100 + 4 * n))));

      // Random data, random input gaps and random out_ready
      ordy_mode = 3;
      clear_obs();
      for (int f = 0; f < 8; f++) begin
         for (int k = 0; k < N; k++) begin
            if ($urandom_range(0, 3) == 0) cycle(1'b0, WL'($urandom), WL'($urandom), get_ordy());
            send_sample(WL'($urandom), WL'($urandom));
         end
      end
      drain();
      chk("rand_count", 32'(got_r.size()), 32'd128);

`ifdef FFT16_OUT_REORDER_SCALE_EN
      // Normalisation corner values
      ordy_mode = 0;
      clear_obs();
      for (int k = 0; k < N; k++) send_sample(16'h7FF8, 16'h8000);
      drain();
      chk("scale_count", 32'(got_r.size()), 32'd16);
      for (int n = 0; n < got_r.size(); n++) begin
         chk("scale_r", 32'(got_r[n]), 32'h0800);
         chk("scale_i", 32'(got_i[n]), 32'hF800);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
